// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and helpers for the pipeline hazard sequencer:
//                FSM state encoding, bundled stall/flush controls, and the
//                load-use detection function.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

   // ABORT is a reserved encoding; the sequencer never enters it on purpose.
   typedef enum logic [1:0] {
      RUN      = 2'b00,
      WAIT_MEM = 2'b01,
      ABORT    = 2'b10
   } hz_state_t;

   // Pipeline control bundle, MSB first in the order the ports are listed.
   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic id_ex_stall;
      logic ex_mem_stall;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_flush;
      logic redirect_take;
   } hazard_ctrl_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // A load in EX whose destination feeds an ID operand; x0 never creates one.
   function automatic logic load_use(
      input logic       ex_is_load,
      input logic [4:0] ex_rd,
      input logic       use_rs1,
      input logic [4:0] rs1,
      input logic       use_rs2,
      input logic [4:0] rs2
   );
      return ex_is_load && (ex_rd != REG_ZERO) &&
             ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_perf_cnt
//  Description : Free-running 32-bit event counters for stall cycles and
//                redirect cycles. Counts wrap modulo 2^32.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_perf_cnt
   import hazard_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_ev_i,
   input  logic        flush_ev_i,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   // Count each event on the same edge that closes the cycle it occurred in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (stall_ev_i) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (flush_ev_i) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule
`default_nettype wire

// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sequencer
//  Description : Central stall/flush controller for the 5-stage pipeline.
//                Handles load-use bubbles, whole-pipe freeze during a data
//                memory wait (with timeout abort), and redirect flushes,
//                including a redirect deferred until the memory wait ends.
//                Optional build macro HAZARD_PERF_EN adds perf counters.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_sequencer
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_W        = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_is_load,
   input  logic        mem_redirect,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   output logic        pc_stall,
   output logic        if_id_stall,
   output logic        id_ex_stall,
   output logic        ex_mem_stall,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        ex_mem_flush,
   output logic        redirect_take,
   output logic        err_timeout,
   output logic [1:0]  state_o
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MEM_TIMEOUT);
   localparam logic [TO_W-1:0] CNT_ONE     = TO_W'(1);
   localparam logic [TO_W-1:0] CNT_MAX     = {TO_W{1'b1}};

   hz_state_t        state_q, state_d;
   logic [TO_W-1:0]  cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             err_q, err_d;
   hazard_ctrl_t     w_ctrl;
   hazard_ctrl_t     w_ctrl_out;
   logic             w_lu;
   logic             w_redirect_now;

   assign w_lu = load_use(ex_is_load, ex_rd, id_use_rs1, id_rs1, id_use_rs2, id_rs2);

   // A redirect may be remembered from earlier in the wait or arrive on the ready cycle.
   assign w_redirect_now = pend_q || mem_redirect;

   // State, wait counter, deferred redirect and sticky error register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end

   // Next-state and Mealy control outputs; memory wait outranks redirect outranks load-use.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      err_d   = err_q;
      w_ctrl  = '0;
      case (state_q)
         RUN: begin
            if (dmem_req && !dmem_ready) begin
               w_ctrl.pc_stall     = 1'b1;
               w_ctrl.if_id_stall  = 1'b1;
               w_ctrl.id_ex_stall  = 1'b1;
               w_ctrl.ex_mem_stall = 1'b1;
               // The waiting access belongs to the branch itself: defer its redirect.
               pend_d  = mem_redirect;
               cnt_d   = CNT_ONE;
               state_d = WAIT_MEM;
            end else if (mem_redirect) begin
               w_ctrl.redirect_take = 1'b1;
               w_ctrl.if_id_flush   = 1'b1;
               w_ctrl.id_ex_flush   = 1'b1;
               w_ctrl.ex_mem_flush  = 1'b1;
            end else if (w_lu) begin
               // One bubble suffices: next cycle EX holds the bubble, not the load.
               w_ctrl.pc_stall    = 1'b1;
               w_ctrl.if_id_stall = 1'b1;
               w_ctrl.id_ex_flush = 1'b1;
            end
         end
         WAIT_MEM: begin
            if (dmem_ready) begin
               if (w_redirect_now) begin
                  w_ctrl.redirect_take = 1'b1;
                  w_ctrl.if_id_flush   = 1'b1;
                  w_ctrl.id_ex_flush   = 1'b1;
                  w_ctrl.ex_mem_flush  = 1'b1;
               end
               pend_d  = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end else if (cnt_q == TIMEOUT_VAL) begin
               // Give up on the access: squash the in-flight work and resume fetching.
               err_d               = 1'b1;
               w_ctrl.if_id_flush  = 1'b1;
               w_ctrl.id_ex_flush  = 1'b1;
               w_ctrl.ex_mem_flush = 1'b1;
               pend_d  = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               w_ctrl.pc_stall     = 1'b1;
               w_ctrl.if_id_stall  = 1'b1;
               w_ctrl.id_ex_stall  = 1'b1;
               w_ctrl.ex_mem_stall = 1'b1;
               pend_d = w_redirect_now;
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
            pend_d  = 1'b0;
         end
      endcase
   end

   // Controls are forced quiet while reset is held, independent of the inputs.
   assign w_ctrl_out = rst_n ? w_ctrl : '0;

   assign pc_stall      = w_ctrl_out.pc_stall;
   assign if_id_stall   = w_ctrl_out.if_id_stall;
   assign id_ex_stall   = w_ctrl_out.id_ex_stall;
   assign ex_mem_stall  = w_ctrl_out.ex_mem_stall;
   assign if_id_flush   = w_ctrl_out.if_id_flush;
   assign id_ex_flush   = w_ctrl_out.id_ex_flush;
   assign ex_mem_flush  = w_ctrl_out.ex_mem_flush;
   assign redirect_take = w_ctrl_out.redirect_take;
   assign err_timeout   = err_q;
   assign state_o       = state_q;

`ifdef HAZARD_PERF_EN
   if (1) begin : g_perf
      hazard_perf_cnt u_perf (
         .clk         (clk),
         .rst_n       (rst_n),
         .stall_ev_i  (w_ctrl_out.pc_stall),
         .flush_ev_i  (w_ctrl_out.redirect_take),
         .stall_cnt_o (perf_stall_cnt),
         .flush_cnt_o (perf_flush_cnt)
      );
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_sequencer
//  Description : Self-checking bench for hazard_sequencer: directed scenarios
//                followed by randomized traffic against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_sequencer;

   localparam int MEM_TIMEOUT = 16;
   localparam int TO_W        = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic       id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0;
   logic       mem_redirect = 0, dmem_req = 0, dmem_ready = 0;
   logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
   logic       if_id_flush, id_ex_flush, ex_mem_flush, redirect_take;
   logic       err_timeout;
   logic [1:0] state_o;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

   always #5 clk = ~clk;

   hazard_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .mem_redirect(mem_redirect),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
      .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .redirect_take(redirect_take),
      .err_timeout(err_timeout), .state_o(state_o)
`ifdef HAZARD_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   // Control bits in port order: 4 stalls, 3 flushes, redirect.
   wire [7:0] obs_ctrl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                          if_id_flush, id_ex_flush, ex_mem_flush, redirect_take};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Behavioural model: "are we waiting on memory, for how many cycles so far,
   // do we owe a redirect, has a timeout ever happened".
   bit          m_waiting;
   int          m_waited;
   bit          m_owed;
   bit          m_err;
   int unsigned m_stalls;
   int unsigned m_redirs;

   task automatic model_reset();
      m_waiting = 0; m_waited = 0; m_owed = 0; m_err = 0;
      m_stalls = 0; m_redirs = 0;
   endtask

   // Called just after a negedge with inputs driven; checks, then advances one clock.
   task automatic step(input string tag);
      bit        hazard;
      bit [7:0]  e;
      bit        n_waiting, n_owed, n_err;
      int        n_waited;
      #1;
      hazard = ex_is_load && ex_rd != 5'd0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      e = 8'h00;
      n_waiting = m_waiting; n_waited = m_waited; n_owed = m_owed; n_err = m_err;
      if (!m_waiting) begin
         if (dmem_req && !dmem_ready) begin
            e = 8'b1111_0000;
            n_waiting = 1; n_waited = 1; n_owed = mem_redirect;
         end else if (mem_redirect) e = 8'b0000_1111;
         else if (hazard)           e = 8'b1100_0100;
      end else if (dmem_ready) begin
         if (m_owed || mem_redirect) e = 8'b0000_1111;
         n_waiting = 0; n_owed = 0;
      end else if (m_waited >= MEM_TIMEOUT) begin
         e = 8'b0000_1110;
         n_err = 1; n_waiting = 0; n_owed = 0;
      end else begin
         e = 8'b1111_0000;
         n_waited = m_waited + 1;
         n_owed = m_owed || mem_redirect;
      end
      check({tag, ":ctrl"}, 32'(obs_ctrl), 32'(e));
      check({tag, ":state"}, 32'(state_o), m_waiting ? 32'd1 : 32'd0);
      check({tag, ":err"}, 32'(err_timeout), 32'(m_err));
`ifdef HAZARD_PERF_EN
      check({tag, ":perf_stall"}, perf_stall_cnt, m_stalls);
      check({tag, ":perf_flush"}, perf_flush_cnt, m_redirs);
`endif
      @(posedge clk);
      m_waiting = n_waiting; m_waited = n_waited; m_owed = n_owed; m_err = n_err;
      m_stalls += 32'(e[7]);
      m_redirs += 32'(e[0]);
      @(negedge clk);
   endtask

   task automatic drive(input bit req, input bit rdy, input bit redir,
                        input bit load, input logic [4:0] rd,
                        input bit u1, input logic [4:0] rs1,
                        input bit u2, input logic [4:0] rs2);
      dmem_req = req; dmem_ready = rdy; mem_redirect = redir;
      ex_is_load = load; ex_rd = rd;
      id_use_rs1 = u1; id_rs1 = rs1; id_use_rs2 = u2; id_rs2 = rs2;
   endtask

   // Assert reset between clock edges with busy inputs; controls must go quiet at once.
   task automatic async_reset(input string tag);
      drive(1, 0, 1, 1, 5'd3, 1, 5'd3, 0, 5'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check({tag, ":rst_ctrl"}, 32'(obs_ctrl), 32'd0);
      check({tag, ":rst_state"}, 32'(state_o), 32'd0);
      check({tag, ":rst_err"}, 32'(err_timeout), 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      // Reset held with a load-use hazard and a redirect on the inputs.
      drive(0, 0, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0);
      @(negedge clk);
      #1;
      check("reset:ctrl", 32'(obs_ctrl), 32'd0);
      check("reset:state", 32'(state_o), 32'd0);
      check("reset:err", 32'(err_timeout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Load-use, then the same with x0 as destination.
      drive(0, 0, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0);  step("lu_hit");
      drive(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);  step("lu_idle");
      drive(0, 0, 0, 1, 5'd0, 1, 5'd0, 0, 5'd0);  step("lu_x0");
      drive(0, 0, 0, 1, 5'd7, 0, 5'd1, 1, 5'd7);  step("lu_rs2");
      // Redirect outranks load-use.
      drive(0, 0, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0);  step("redir_first");

      // Memory wait: three stalled cycles then ready.
      drive(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      repeat (3) step("memwait");
      drive(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);  step("memwait_rdy");
      drive(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);  step("memwait_after");

      // Redirect in the entry cycle, paid out on the ready cycle only.
      drive(1, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0);  step("pend_entry");
      drive(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      repeat (3) step("pend_wait");
      drive(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);  step("pend_rdy");
      drive(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      repeat (2) step("pend_after");

      // Timeout, and the error stays set afterwards.
      drive(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      repeat (MEM_TIMEOUT + 1) step("timeout");
      drive(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      repeat (3) step("timeout_sticky");

      // Async reset while waiting with a redirect owed.
      drive(1, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0);  step("arst_entry");
      drive(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);  step("arst_wait");
      async_reset("arst");
      drive(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      repeat (2) step("arst_after");

      // Randomized traffic with varying memory latency.
      for (int i = 0; i < 3000; i++) begin
         int rdy_pct;
         rdy_pct = (i / 200) % 3 == 0 ? 50 : ((i / 200) % 3 == 1 ? 15 : 2);
         drive($urandom_range(0, 99) < 35,
               $urandom_range(0, 99) < rdy_pct,
               $urandom_range(0, 99) < 15,
               $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 3)),
               $urandom_range(0, 99) < 70, 5'($urandom_range(0, 3)),
               $urandom_range(0, 99) < 70, 5'($urandom_range(0, 3)));
         step("rand");
         if (i % 1000 == 777) async_reset("rand_arst");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central stall/flush controller for the 5-stage pipeline (IF/ID/EX/MEM/WB) driven by the decoder's id/ex/mem/wb control bundles.
- Detects load-use hazards between ID and EX.
- Freezes the whole pipeline while the data memory handshake is outstanding.
- Sequences the flush after a taken branch or jump resolves in MEM, including a redirect that arrives during a memory wait.

Parameters:
- MEM_TIMEOUT, 16, max consecutive WAIT_MEM cycles before timeout abort (≥2).
- TO_W, 5, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  EX destination register
- ex_is_load  in  1  EX holds a load (MemtoReg==1 && RegWrite)
- mem_redirect  in  1  MEM: taken branch or jump, PC must redirect
- dmem_req  in  1  MEM stage drives a load/store request
- dmem_ready  in  1  data memory completes the request this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID register
- id_ex_stall  out  1  hold ID/EX register
- ex_mem_stall  out  1  hold EX/MEM register
- if_id_flush  out  1  bubble into IF/ID
- id_ex_flush  out  1  bubble into ID/EX
- ex_mem_flush  out  1  bubble into EX/MEM
- redirect_take  out  1  PC mux selects the redirect target this cycle
- err_timeout  out  1  sticky memory-timeout flag
- state_o  out  2  current FSM state, for debug

Behaviour:
- Reset (async, rst_n low):
  - state = RUN; wait counter = 0; pend_redirect = 0; err_timeout = 0.
  - All stall, flush and redirect outputs are 0 while reset is asserted.
- Outputs are Mealy, combinational from state and inputs. State, counter and pend_redirect update on posedge clk.
- Load-use hazard: lu = ex_is_load && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd)).
- State RUN, priority mem-wait > redirect > load-use:
  - Wait: dmem_req && !dmem_ready.
    - Assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall.
    - If mem_redirect, set pend_redirect = 1 (the request is the branch/jump's own MEM slot).
    - Counter = 1; next state WAIT_MEM.
  - Else mem_redirect:
    - Assert redirect_take, if_id_flush, id_ex_flush, ex_mem_flush.
    - Load-use is ignored (the victim is flushed). Stay in RUN.
  - Else lu:
    - Assert pc_stall, if_id_stall, id_ex_flush for exactly this cycle.
    - Stay in RUN. The next cycle re-evaluates with the bubble in EX, so no repeat.
  - Else all outputs 0.
- State WAIT_MEM:
  - All four stalls are asserted while !dmem_ready.
  - mem_redirect seen in this state ORs into pend_redirect.
  - On dmem_ready:
    - Stalls drop this cycle.
    - If pend_redirect: assert redirect_take and the three flushes this cycle, then clear pend_redirect.
    - Next state RUN.
  - Without dmem_ready:
    - Counter increments each cycle.
    - When counter == MEM_TIMEOUT: set err_timeout, drop stalls, assert the three flushes, clear pend_redirect, next state RUN.
- Counter saturates and never wraps.
- err_timeout is cleared only by reset.
- State ABORT (encoding 2'b10) is reserved and unused; any illegal state recovers to RUN on the next clock.
- Reset asserted mid-WAIT_MEM discards the pending redirect and the counter.

Optional Feature:
- HAZARD_PERF_EN defined:
  - Adds outputs perf_stall_cnt[31:0] (cycles with pc_stall=1) and perf_flush_cnt[31:0] (cycles with redirect_take=1).
  - Counters reset to 0, wrap mod 2^32, and increment on the same edge as the event.
- Undefined: the ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- hazard_pkg holds:
  - hz_state_t enum: RUN=2'b00, WAIT_MEM=2'b01, ABORT=2'b10.
  - The hazard_ctrl_t struct bundling the seven stall/flush signals plus redirect_take.
  - Constant REG_ZERO = 5'd0.
- One sub-module, hazard_perf_cnt, holds the two optional counters and is instantiated only under HAZARD_PERF_EN.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → pc_stall, if_id_stall, id_ex_flush =1 for one cycle. Repeat with ex_rd=0 → no stall.
- Redirect-first priority: mem_redirect=1 and the load-use hazard in the same cycle → redirect_take and all three flushes =1, pc_stall=0.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 → all stalls high for 3 cycles, state_o=01, zero stall on the ready cycle, back to RUN.
- Redirect during wait: mem_redirect pulses in the entry cycle, ready arrives 4 cycles later → redirect_take and flushes asserted exactly on the ready cycle, once.
- Timeout: dmem_ready held 0 with MEM_TIMEOUT=16 → err_timeout=1 after 16 wait cycles, flushes pulse, state RUN; err_timeout persists until rst_n=0.
- Async reset mid-WAIT_MEM: drop rst_n between clocks → outputs 0 immediately; after release, state_o=00 and no redirect is issued.
